// File: rtl/fp_unit_arbiter_if.sv
// Requester-side bus of the FP unit arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface fp_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_A;
  logic [NREQ*W-1:0] req_B;
  logic [NREQ-1:0]   req_op;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              busy;

  modport master (
    output req, req_A, req_B, req_op,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, req_A, req_B, req_op,
    output gnt, done, result, busy
  );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter that shares one fixed-latency, non-pipelined FP unit
// between NREQ requesters. Only one operation is in flight at a time. The
// winner's operands are held on fu_A/fu_B/fu_op until the next grant.
//
// state  | meaning
// IDLE   | no operation in flight; requests are sampled and one is granted
// WAIT   | unit is computing; cnt counts edges up to LATENCY
// RETIRE | done/result cycle; requests are not sampled
module fp_unit_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 6,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_arb_if.slave      bus,
  output logic         fu_start,
  output logic [W-1:0] fu_A,
  output logic [W-1:0] fu_B,
  output logic         fu_op,
  input  logic [W-1:0] fu_Y
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              fu_start_q, fu_start_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      result_q, result_d;
  logic [W-1:0]      fu_A_q, fu_A_d;
  logic [W-1:0]      fu_B_q, fu_B_d;
  logic              fu_op_q, fu_op_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              win_found;
  logic [IDXW-1:0]   win_idx;

  // Requester index at offset 'off' from 'base', wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDXW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin pick: scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    win_found = |bus.req;
    win_idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[rr_idx(ptr_q, k)]) win_idx = rr_idx(ptr_q, k);
    end
  end

  // Next-state and next-output logic; pulses default low so each lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    done_d     = '0;
    fu_start_d = 1'b0;
    busy_d     = busy_q;
    result_d   = result_q;
    fu_A_d     = fu_A_q;
    fu_B_d     = fu_B_q;
    fu_op_d    = fu_op_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = onehot(win_idx);
          fu_A_d     = bus.req_A[win_idx*W +: W];
          fu_B_d     = bus.req_B[win_idx*W +: W];
          fu_op_d    = bus.req_op[win_idx];
          fu_start_d = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          win_d      = win_idx;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNTW'(LATENCY)) begin
          result_d = fu_Y;
          done_d   = onehot(win_q);
          ptr_d    = (win_q == IDXW'(NREQ - 1)) ? '0 : IDXW'(win_q + 1'b1);
          state_d  = RETIRE;
        end else begin
          cnt_d = CNTW'(cnt_q + 1'b1);
        end
      end
      RETIRE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight result without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      fu_start_q <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      fu_A_q     <= '0;
      fu_B_q     <= '0;
      fu_op_q    <= 1'b0;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      fu_start_q <= fu_start_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      fu_A_q     <= fu_A_d;
      fu_B_q     <= fu_B_d;
      fu_op_q    <= fu_op_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign fu_start   = fu_start_q;
  assign fu_A       = fu_A_q;
  assign fu_B       = fu_B_q;
  assign fu_op      = fu_op_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a behavioural 6-cycle FP add/sub unit.
module tb_fp_unit_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 6;
  localparam int W    = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fu_start;
  logic [W-1:0] fu_A;
  logic [W-1:0] fu_B;
  logic         fu_op;
  logic [W-1:0] fu_Y = '0;

  always #5 clk = ~clk;

  fp_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  fp_unit_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fu_start (fu_start),
    .fu_A     (fu_A),
    .fu_B     (fu_B),
    .fu_op    (fu_op),
    .fu_Y     (fu_Y)
  );

  // Single precision <-> real, for normal numbers and zero only.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  // FP unit model: samples start, shows garbage until Y becomes valid LAT cycles later.
  int          pend = 0;
  logic [31:0] y_next = '0;
  always @(posedge clk) begin
    if (fu_start) begin
      y_next <= r2sp(fu_op ? (sp2r(fu_A) - sp2r(fu_B)) : (sp2r(fu_A) + sp2r(fu_B)));
      fu_Y   <= 32'hDEADBEEF;
      pend   <= LAT - 1;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) fu_Y <= y_next;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event counters and invariant violations sampled mid-cycle.
  int gnt_cnt [NREQ] = '{default: 0};
  int done_cnt[NREQ] = '{default: 0};
  int viol = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.gnt[i])  gnt_cnt[i]  <= gnt_cnt[i] + 1;
      if (bus.done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
    viol <= viol + (((bus.gnt != '0) && (bus.done != '0)) ? 1 : 0)
                 + ($onehot0(bus.gnt) ? 0 : 1)
                 + ($onehot0(bus.done) ? 0 : 1)
                 + ((fu_start != (bus.gnt != '0)) ? 1 : 0);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.req_A[i*W +: W] = a;
    bus.req_B[i*W +: W] = b;
    bus.req_op[i]       = op;
  endtask

  task automatic wait_gnt(input int max, output int idx, output int c);
    idx = -1;
    c   = cyc;
    for (int n = 0; n < max; n++) begin
      tick();
      if (bus.gnt != '0) break;
    end
    if (bus.gnt == '0) chk("gnt_timeout", 64'(bus.gnt != '0), 64'd1);
    idx = first_idx(bus.gnt);
    c   = cyc;
  endtask

  task automatic wait_done(input int max, output int idx, output int c);
    idx = -1;
    c   = cyc;
    for (int n = 0; n < max; n++) begin
      tick();
      if (bus.done != '0) break;
    end
    if (bus.done == '0) chk("done_timeout", 64'(bus.done != '0), 64'd1);
    idx = first_idx(bus.done);
    c   = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gi, gc, di, dc, prev_gc, snap_g, snap_d;
    logic [31:0] t2_exp [NREQ];
    t2_exp = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h41000000};

    rst_n      = 1'b0;
    bus.req    = '0;
    bus.req_A  = '0;
    bus.req_B  = '0;
    bus.req_op = '0;
    #12;
    chk("rst_pulses", {bus.gnt, bus.done, fu_start, bus.busy}, '0);
    chk("rst_result", bus.result, 0);
    chk("rst_fu_ops", {fu_A, fu_B, fu_op}, '0);

    // Single subtract op: 3.0 - 1.0
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0, 32'h40400000, 32'h3F800000, 1'b1);
    bus.req = 4'b0001;
    tick();
    gc = cyc;
    chk("t1_gnt", bus.gnt, 4'b0001);
    chk("t1_start_busy", {fu_start, bus.busy}, 2'b11);
    chk("t1_fu_ops", {fu_A, fu_B, fu_op}, {32'h40400000, 32'h3F800000, 1'b1});
    bus.req = '0;
    for (int n = 0; n < LAT; n++) begin
      tick();
      chk("t1_wait", {bus.gnt, bus.done, fu_start, bus.busy}, {4'b0, 4'b0, 1'b0, 1'b1});
    end
    tick();
    chk("t1_done", bus.done, 4'b0001);
    chk("t1_result", bus.result, 32'h40000000);
    chk("t1_busy_done", bus.busy, 1);
    chk("t1_latency", cyc - gc, 7);
    tick();
    chk("t1_after", {bus.done, bus.busy}, '0);

    // All four request at once from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    set_op(1, 32'h40A00000, 32'h3F800000, 1'b1);
    set_op(2, 32'h3FC00000, 32'h3F000000, 1'b0);
    set_op(3, 32'h41200000, 32'h40000000, 1'b1);
    bus.req = 4'b1111;
    prev_gc = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_gnt(20, gi, gc);
      chk("t2_gnt_idx", gi, k);
      if (k > 0) chk("t2_gnt_gap", gc - prev_gc, 9);
      prev_gc = gc;
      bus.req = bus.req & ~(4'b0001 << gi);
      wait_done(20, di, dc);
      chk("t2_done_idx", di, k);
      chk("t2_latency", dc - gc, 7);
      chk("t2_result", bus.result, t2_exp[k]);
    end

    // Round-robin wrap: serve 2, then 1001 -> 3 then 0, then 0 three times
    bus.req = 4'b0100;
    wait_gnt(20, gi, gc);
    chk("t3_gnt2", gi, 2);
    bus.req = '0;
    wait_done(20, di, dc);
    bus.req = 4'b1001;
    wait_gnt(20, gi, gc);
    chk("t3_gnt3", gi, 3);
    bus.req = 4'b0001;
    wait_done(20, di, dc);
    chk("t3_done3", di, 3);
    chk("t3_result3", bus.result, 32'h41000000);
    prev_gc = gc;
    for (int r = 0; r < 3; r++) begin
      wait_gnt(20, gi, gc);
      chk("t3_gnt0", gi, 0);
      chk("t3_gap", gc - prev_gc, 9);
      prev_gc = gc;
      if (r == 2) bus.req = '0;
      wait_done(20, di, dc);
      chk("t3_result0", bus.result, 32'h40400000);
    end

    // Withdrawn request gets nothing
    bus.req = 4'b0001;
    wait_gnt(20, gi, gc);
    chk("t4_gnt0", gi, 0);
    bus.req = '0;
    tick();
    tick();
    snap_g = gnt_cnt[1];
    snap_d = done_cnt[1];
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    wait_done(20, di, dc);
    chk("t4_done0", di, 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t4_no_gnt", bus.gnt, 4'b0000);
    end
    chk("t4_gnt1_cnt", gnt_cnt[1], snap_g);
    chk("t4_done1_cnt", done_cnt[1], snap_d);

    // Reset during WAIT
    set_op(0, 32'h40400000, 32'h3F800000, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(20, gi, gc);
    bus.req = '0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pulses", {bus.gnt, bus.done, fu_start, bus.busy}, '0);
    chk("t5_rst_result", bus.result, 0);
    chk("t5_rst_fu_ops", {fu_A, fu_B, fu_op}, '0);
    snap_d = done_cnt[0];
    tick();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    chk("t5_no_done", done_cnt[0], snap_d);
    bus.req = 4'b0011;
    wait_gnt(20, gi, gc);
    chk("t5_ptr_reset", gi, 0);
    bus.req = '0;
    wait_done(20, di, dc);
    chk("t5_result0", bus.result, 32'h40800000);
    bus.req = 4'b0100;
    wait_gnt(20, gi, gc);
    chk("t5_gnt2", gi, 2);
    bus.req = '0;
    wait_done(20, di, dc);
    chk("t5_result2", bus.result, 32'h40000000);

    // Operands held while requester changes its inputs
    set_op(0, 32'h40400000, 32'h3F800000, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(20, gi, gc);
    bus.req = '0;
    set_op(0, 32'h42000000, 32'h41000000, 1'b1);
    for (int n = 0; n < LAT; n++) begin
      tick();
      chk("t6_fu_hold", {fu_A, fu_B, fu_op}, {32'h40400000, 32'h3F800000, 1'b0});
    end
    wait_done(20, di, dc);
    chk("t6_result", bus.result, 32'h40800000);
    chk("t6_fu_after", fu_A, 32'h40400000);

    chk("invariants", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
